// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, FSM state type and the six bitwise helper functions
package sha256_pkg;
  typedef enum logic [2:0] {LOAD, RND1, FIN1, RND2, FIN2, DONE} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  // Index 0 holds H0 so the packed vector lines up with a..h working registers.
  localparam logic [7:0][31:0] H_INIT = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  // Second block for a 64-byte message: W0 = 0x80000000, W15 = bit length 512.
  localparam logic [15:0][31:0] PAD_BLOCK = {32'h00000200, 448'h0, 32'h80000000};
  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round
// Ports: i_v = a..h (a at index 0), i_k = Kt, i_w = Wt, o_v = a..h after the round.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] i_v,
  input  logic [31:0]      i_k,
  input  logic [31:0]      i_w,
  output logic [7:0][31:0] o_v
);
  logic [31:0] w_t1, w_t2;
  assign w_t1 = i_v[7] + bsig1(i_v[4]) + ch(i_v[4], i_v[5], i_v[6]) + i_k + i_w;
  assign w_t2 = bsig0(i_v[0]) + maj(i_v[0], i_v[1], i_v[2]);
  assign o_v  = {i_v[6], i_v[5], i_v[4], i_v[3] + w_t1, i_v[2], i_v[1], i_v[0], w_t1 + w_t2};
endmodule

// File: rtl/sha256_64byte_hasher.sv
// sha256_64byte_hasher: free-running SHA-256 of one fixed 64-byte message (message block + padding block)
// Ports: clk, rst (async active-high), msg_in (W0 at LSBs, big-endian words), final_out (H0 at MSBs).
// Macro SHA256_DUAL_ROUND_EN: two chained rounds per clock, digest at cycle 66 instead of 130.
module sha256_64byte_hasher
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] msg_in,
  output logic [255:0] final_out
);
  state_t            r_state, w_next;
  logic [7:0][31:0]  r_h, r_v, w_v_rnd, w_hsum, w_v1;
  logic [15:0][31:0] r_w, w_w_next;
  logic [5:0]        r_cnt;
  logic [31:0]       w_new1;
  logic              w_last;
  assign w_new1 = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
  sha256_round u_r0 (.i_v(r_v), .i_k(K[r_cnt]), .i_w(r_w[0]), .o_v(w_v1));
`ifdef SHA256_DUAL_ROUND_EN
  localparam logic [5:0] STEP = 6'd2;
  logic [31:0] w_new2;
  logic [5:0]  w_cnt1;
  assign w_cnt1   = r_cnt + 6'd1;
  assign w_new2   = ssig1(r_w[15]) + r_w[10] + ssig0(r_w[2]) + r_w[1];
  assign w_w_next = {w_new2, w_new1, r_w[15:2]};
  sha256_round u_r1 (.i_v(w_v1), .i_k(K[w_cnt1]), .i_w(r_w[1]), .o_v(w_v_rnd));
`else
  localparam logic [5:0] STEP = 6'd1;
  assign w_w_next = {w_new1, r_w[15:1]};
  assign w_v_rnd  = w_v1;
`endif
  assign w_last = r_cnt == 6'd0 - STEP;
  always_comb begin
    for (int i = 0; i < 8; i++) w_hsum[i] = r_h[i] + r_v[i];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = RND1;
      RND1:    w_next = w_last ? FIN1 : RND1;
      FIN1:    w_next = RND2;
      RND2:    w_next = w_last ? FIN2 : RND2;
      default: w_next = DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h       <= '0;
      r_v       <= '0;
      r_w       <= '0;
      r_cnt     <= '0;
      final_out <= '0;
    end else if (r_state == LOAD) begin
      r_w   <= msg_in;
      r_h   <= H_INIT;
      r_v   <= H_INIT;
      r_cnt <= '0;
    end else if (r_state == RND1 || r_state == RND2) begin
      r_v   <= w_v_rnd;
      r_w   <= w_w_next;
      r_cnt <= r_cnt + STEP;
    end else if (r_state == FIN1) begin
      r_h <= w_hsum;
      r_v <= w_hsum;
      r_w <= PAD_BLOCK;
    end else if (r_state == FIN2) begin
      r_h       <= w_hsum;
      final_out <= {w_hsum[0], w_hsum[1], w_hsum[2], w_hsum[3],
                    w_hsum[4], w_hsum[5], w_hsum[6], w_hsum[7]};
    end
  end
endmodule

// File: tb/tb_sha256_64byte_hasher.sv
// tb_sha256_64byte_hasher: directed self-checking bench for sha256_64byte_hasher
module tb_sha256_64byte_hasher;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] msg_in = '0;
  logic [255:0] final_out;
  logic [511:0] ascii;
  logic [255:0] golden, held;
  int tests = 0;
  int fails = 0;
`ifdef SHA256_DUAL_ROUND_EN
  localparam int LAT = 67;
`else
  localparam int LAT = 131;
`endif
  localparam logic [255:0] ZERO_DIG = 256'hf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  always #5 clk = ~clk;

  sha256_64byte_hasher dut (.clk(clk), .rst(rst), .msg_in(msg_in), .final_out(final_out));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 8; i++) h[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++)
      if (t < 16) w[t] = blk[32*t +: 32];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    v = h;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = h[i] + v[i];
    return hout;
  endfunction

  function automatic logic [255:0] sha_model(input logic [511:0] m);
    logic [511:0] pad;
    pad = {32'h00000200, 448'h0, 32'h80000000};
    return compress(compress(IV, m), pad);
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ascii  = {4{32'h34333232, 32'h31323335, 32'h77726c64, 32'h68656c6f}};
    golden = sha_model(ascii);
    #2 check("reset_out", final_out, '0);
    #4 check("reset_hold", final_out, '0);
    release_rst();
    edges(1);
    check("zero_cycle0", final_out, '0);
    edges(LAT - 2);
    check("zero_before_valid", final_out, '0);
    edges(1);
    check("zero_digest", final_out, ZERO_DIG);
    held = final_out;
    for (int i = 0; i < 500; i++) begin
      edges(1);
      check("hold_stable", final_out, ZERO_DIG);
    end
    rst = 1'b1;
    #1 check("async_clear", final_out, '0);
    msg_in = ascii;
    release_rst();
    edges(LAT - 1);
    check("ascii_before_valid", final_out, '0);
    edges(1);
    check("ascii_digest", final_out, golden);
    check("ascii_differs", final_out == held, 256'd0);
    rst = 1'b1;
    #1;
    release_rst();
    edges(5);
    msg_in = '1;
    edges(LAT - 5);
    check("input_ignored", final_out, golden);
    rst = 1'b1;
    #1;
    msg_in = ascii;
    release_rst();
    edges(71);
    check("midrun_pre_reset", final_out, (LAT <= 71) ? golden : 256'd0);
    rst = 1'b1;
    #1 check("midrun_clear", final_out, '0);
    msg_in = '0;
    @(posedge clk);
    release_rst();
    edges(LAT - 1);
    check("restart_before_valid", final_out, '0);
    edges(1);
    check("restart_digest", final_out, ZERO_DIG);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha256_64byte_hasher.md
Name: sha256_64byte_hasher

Overview:
- Computes the complete SHA-256 digest of a fixed 64-byte (512-bit) message presented in parallel on `msg_in`.
- Internally runs two compression blocks:
  - block 1: the message itself;
  - block 2: the standard padding block (0x80, zeros, 64-bit length 512).
- Free-running. No handshake: after reset release it hashes once and holds the digest.
- Used as a standalone hashing core under a top-level wrapper.

Parameters:
- None. Sizes are fixed by SHA-256.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `msg_in`  input  512  message block. Word Wi = msg_in[32*i+31 : 32*i], so W0 is at the LSBs. Each word is big-endian: its first message byte is in bits [31:24] of the word.
- `final_out`  output  256  digest. H0 at [255:224], H7 at [31:0], giving standard big-endian digest byte order.

Behaviour:
- Reset (async, `rst`=1):
  - FSM goes to LOAD.
  - `final_out` = 0.
  - Working registers a..h, H0..H7, the 16-word schedule window and the round counter are all cleared.
- FSM states and timing. Cycle n means the n-th rising edge after `rst` falls.
  - LOAD (cycle 0):
    - capture `msg_in` into the W window;
    - H0..H7 = FIPS 180-4 initial values;
    - a..h = H0..H7 initial values.
  - RND1 (cycles 1-64):
    - one compression round per cycle, t = 0..63;
    - W window is a 16-entry shift register; Wt for t ≥ 16 = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16;
    - all additions mod 2^32.
  - FIN1 (cycle 65):
    - Hi += working variable i (mod 2^32);
    - a..h = updated H;
    - W window loaded with the padding block: W0 = 0x80000000, W1..W14 = 0, W15 = 0x00000200.
  - RND2 (cycles 66-129): 64 rounds, same as RND1.
  - FIN2 (cycle 130):
    - Hi += working variable i;
    - `final_out` = {H0..H7}.
  - DONE: hold `final_out` and all state until the next reset.
- `final_out` reads 0 from reset through cycle 129, then holds the digest from cycle 130 onward.
- `msg_in` is sampled only at LOAD. Later changes are ignored until the next reset.
- Reset asserted mid-computation aborts immediately. After release the core restarts at LOAD.
- Round constants K0..K63 and initial H values are as defined in FIPS 180-4.

Optional Feature:
- Macro `SHA256_DUAL_ROUND_EN`.
- Defined:
  - two rounds per clock;
  - each RND state lasts 32 cycles;
  - `final_out` is valid at cycle 66 (LOAD 0, RND1 1-32, FIN1 33, RND2 34-65, FIN2 66);
  - the schedule window advances two words per cycle.
- Undefined: one round per clock as above. Digest values are identical in both builds.

Decomposition:
- Package `sha256_pkg`:
  - K[0:63] constant array;
  - H_INIT[0:7];
  - padding-block constant;
  - FSM state enum;
  - functions Ch, Maj, Σ0, Σ1, σ0, σ1.
- Sub-module `sha256_round`: combinational single round, taking a..h, Kt and Wt and producing next a..h.
  - Instantiated once by default;
  - chained twice under `SHA256_DUAL_ROUND_EN`.

Test Plan:
- Reset hold: `rst`=1 for 5 ns with `msg_in`=0 → `final_out`=0 throughout. Release reset, then `msg_in`=0 → after 131 edges `final_out` equals the software SHA-256 of 64 zero bytes:
  - 0xf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b.
- ASCII block: `msg_in` words W0..W15 = {68656c6f, 77726c64, 31323335, 34333232} repeated 4×, i.e. "helowrld12354322" ×4 → `final_out` equals the golden-model SHA-256 of those 64 bytes. It must be 0 at cycle 129 and valid from cycle 130; run the bench 15 µs at a 10 ns clock.
- Input change after LOAD: switch `msg_in` to all-ones at cycle 5 → digest is unchanged versus the unchanged-input run.
- Mid-run reset: assert `rst` at cycle 70 for one cycle, then release → `final_out` is 0 immediately and the correct digest appears 131 edges after release.
- Hold: after DONE, run 500 further cycles → `final_out` is stable.
- `SHA256_DUAL_ROUND_EN` build: the same two vectors → identical digests, valid at cycle 66.
